// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: one pending word plus a shifter, streaming
// words gaplessly onto seq_out/seq_valid toward the sequence detectors.
module seq_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             en,
   output logic             seq_out,
   output logic             seq_valid,
   output logic             busy,
   output logic [1:0]       state_out
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_PRE = CW'(WIDTH - 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LAST  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] sh, sh_n;
   logic [WIDTH-1:0] pend, pend_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             pend_full, pend_full_n;
   logic             accept;
   logic             load;
   logic             step;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sh        <= '0;
         pend      <= '0;
         cnt       <= '0;
         pend_full <= 1'b0;
      end else begin
         state     <= state_n;
         sh        <= sh_n;
         pend      <= pend_n;
         cnt       <= cnt_n;
         pend_full <= pend_full_n;
      end
   end

   // Accept and load are mutually exclusive: accept needs an empty pending slot, load a full one.
   always_comb begin
      state_n     = state;
      sh_n        = sh;
      pend_n      = pend;
      cnt_n       = cnt;
      pend_full_n = pend_full;
      step        = (state != IDLE) && en;
      accept      = in_valid && in_ready;
      load        = pend_full && ((state == IDLE) || ((state == LAST) && en));

      case (state)
         IDLE: begin
            state_n = IDLE;
         end
         SHIFT: begin
            if (en) begin
               sh_n  = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
               cnt_n = cnt + CW'(1);
               if (cnt == CNT_PRE) begin
                  state_n = LAST;
               end
            end
         end
         LAST: begin
            if (en) begin
               sh_n    = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      if (load) begin
         sh_n        = pend;
         cnt_n       = '0;
         state_n     = SHIFT;
         pend_full_n = 1'b0;
      end

      if (accept) begin
         pend_n      = in_data;
         pend_full_n = 1'b1;
      end
   end

   assign in_ready  = !pend_full && !rst;
   assign seq_valid = step;
   assign busy      = (state != IDLE) || pend_full;
   assign seq_out   = (state == IDLE) ? IDLE_BIT : (MSB_FIRST ? sh[WIDTH-1] : sh[0]);
   assign state_out = state;

endmodule
